// File: rtl/analyzer_pkg.sv
// Shared types and address arithmetic for the capture and readback FSMs.
package analyzer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRETRIG,
      ST_ARMED,
      ST_POSTTRIG,
      ST_FLUSH,
      ST_DONE
   } cap_state_e;

   // Number of packet slots in the circular sample memory.
   function automatic logic [31:0] calc_num_packets(input longint unsigned cap,
                                                    input longint unsigned word_w,
                                                    input longint unsigned pkt_w);
      return 32'(cap / word_w / (pkt_w / 64'd8 / word_w));
   endfunction

   function automatic logic [31:0] calc_max_sample_number(input longint unsigned cap,
                                                          input longint unsigned word_w,
                                                          input longint unsigned pkt_w);
      return calc_num_packets(cap, word_w, pkt_w) - 32'd1;
   endfunction

   // (a + b) mod n; b may be any 32-bit value.
   function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] n);
      return 32'((64'(a) + 64'(b)) % 64'(n));
   endfunction

   // (a - b) mod n; a is expected to already be below n.
   function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] n);
      return 32'((64'(a) + 64'(n) - (64'(b) % 64'(n))) % 64'(n));
   endfunction

endpackage

// File: rtl/analyzer_capture_fifo.sv
// Synchronous first-word-fall-through packet FIFO; head is valid whenever !empty.
module analyzer_capture_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign head  = mem_q[rp_q[AW-1:0]];

   // Pointer and storage update; caller only pushes when a slot is (or is being) freed.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      mem_d = mem_q;
      if (push) begin
         mem_d[wp_q[AW-1:0]] = din;
         wp_d = wp_q + 1'b1;
      end
      if (pop && !empty) rp_d = rp_q + 1'b1;
   end

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

endmodule

// File: rtl/analyzer_capture_fsm.sv
// Capture stage: timestamps samples, buffers them, writes them to the circular
// memory and publishes the captured window around the trigger.
module analyzer_capture_fsm
   import analyzer_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH        = 16,
   parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
   parameter int unsigned MEMORY_CAPACITY     = 2**27,
   parameter int unsigned MEMORY_WORD_WIDTH   = 2,
   parameter int unsigned FIFO_DEPTH          = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           arm,
   input  logic                           trigger,
   input  logic                           sample_valid,
   input  logic [SAMPLE_WIDTH-1:0]        sample_data,
   input  logic [31:0]                    pre_count,
   input  logic [31:0]                    post_count,
   input  logic                           write_allowed,
   output logic                           write_req,
   output logic [31:0]                    writeSampleNumber,
   output logic [SAMPLE_PACKET_WIDTH-1:0] writePacket,
   output logic                           idle,
   output logic                           capture_done,
   output logic                           overflow,
   output logic [31:0]                    sampleNumber_Begin,
   output logic [31:0]                    sampleNumber_End
);
   localparam int unsigned TS_W = SAMPLE_PACKET_WIDTH - SAMPLE_WIDTH;
   localparam logic [31:0] N    = calc_num_packets(64'(MEMORY_CAPACITY),
                                     64'(MEMORY_WORD_WIDTH), 64'(SAMPLE_PACKET_WIDTH));
   localparam logic [31:0] MAX  = N - 32'd1;

   cap_state_e      state_q, state_d;
   logic [31:0]     pre_q, pre_d, post_q, post_d;
   logic [31:0]     pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
   logic [31:0]     t_q, t_d;
   logic            t_set_q, t_set_d;
   logic [31:0]     enq_addr_q, enq_addr_d, wr_addr_q, wr_addr_d;
   logic [TS_W-1:0] ts_q, ts_d;
   logic            overflow_q, overflow_d;
   logic [31:0]     begin_q, begin_d, end_q, end_d;

   logic            fifo_full, fifo_empty, push, pop, capturing, drop;
   logic [31:0]     pre_lim, pre_sat;

   function automatic logic [31:0] next_addr(input logic [31:0] a);
      return (a == MAX) ? 32'd0 : a + 32'd1;
   endfunction

   analyzer_capture_fifo #(
      .WIDTH(SAMPLE_PACKET_WIDTH),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({ts_q, sample_data}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (writePacket)
   );

   assign capturing = state_q inside {ST_PRETRIG, ST_ARMED, ST_POSTTRIG};
   assign pop       = !fifo_empty && write_allowed;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign push      = capturing && sample_valid && (!fifo_full || pop);
   assign drop      = capturing && sample_valid && fifo_full && !pop;

   // Pre-trigger depth is limited so pre + post + trigger packet fit the buffer.
   assign pre_lim = (post_count >= MAX) ? 32'd0 : MAX - post_count;
   assign pre_sat = (pre_count > pre_lim) ? pre_lim : pre_count;

   assign write_req          = !fifo_empty;
   assign writeSampleNumber  = wr_addr_q;
   assign idle               = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign capture_done       = (state_q == ST_DONE);
   assign overflow           = overflow_q;
   assign sampleNumber_Begin = begin_q;
   assign sampleNumber_End   = end_q;

   // Next-state, counters and window arithmetic.
   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      post_d     = post_q;
      pre_cnt_d  = pre_cnt_q;
      post_cnt_d = post_cnt_q;
      t_d        = t_q;
      t_set_d    = t_set_q;
      enq_addr_d = push ? next_addr(enq_addr_q) : enq_addr_q;
      wr_addr_d  = pop ? next_addr(wr_addr_q) : wr_addr_q;
      ts_d       = ts_q + TS_W'(1);
      overflow_d = overflow_q | drop;
      begin_d    = begin_q;
      end_d      = end_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               state_d    = (pre_sat == 32'd0) ? ST_ARMED : ST_PRETRIG;
               pre_d      = pre_sat;
               post_d     = post_count;
               pre_cnt_d  = '0;
               post_cnt_d = '0;
               t_set_d    = 1'b0;
               enq_addr_d = '0;
               wr_addr_d  = '0;
               ts_d       = '0;
               overflow_d = 1'b0;
            end
         end
         ST_PRETRIG: begin
            if (push) begin
               pre_cnt_d = pre_cnt_q + 32'd1;
               if (pre_cnt_q + 32'd1 == pre_q) state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // A dropped trigger sample defers T to the next enqueued packet.
            if (sample_valid && trigger) begin
               t_set_d    = push;
               t_d        = enq_addr_q;
               post_cnt_d = '0;
               state_d    = (push && post_q == 32'd0) ? ST_FLUSH : ST_POSTTRIG;
            end
         end
         ST_POSTTRIG: begin
            if (push) begin
               if (!t_set_q) begin
                  t_set_d = 1'b1;
                  t_d     = enq_addr_q;
                  if (post_q == 32'd0) state_d = ST_FLUSH;
               end else begin
                  post_cnt_d = post_cnt_q + 32'd1;
                  if (post_cnt_q + 32'd1 == post_q) state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (fifo_empty) begin
               state_d = ST_DONE;
               begin_d = mod_sub(t_q, pre_q, N);
               end_d   = mod_add(mod_add(t_q, post_q, N), 32'd1, N);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pre_q      <= '0;
         post_q     <= '0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         t_q        <= '0;
         t_set_q    <= 1'b0;
         enq_addr_q <= '0;
         wr_addr_q  <= '0;
         ts_q       <= '0;
         overflow_q <= 1'b0;
         begin_q    <= '0;
         end_q      <= '0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         post_q     <= post_d;
         pre_cnt_q  <= pre_cnt_d;
         post_cnt_q <= post_cnt_d;
         t_q        <= t_d;
         t_set_q    <= t_set_d;
         enq_addr_q <= enq_addr_d;
         wr_addr_q  <= wr_addr_d;
         ts_q       <= ts_d;
         overflow_q <= overflow_d;
         begin_q    <= begin_d;
         end_q      <= end_d;
      end
   end

endmodule

// File: tb/tb_analyzer_capture_fsm.sv
// Scoreboard bench for analyzer_capture_fsm with a 16-slot memory and 4-deep FIFO.
module tb_analyzer_capture_fsm;
   logic        clk = 1'b0;
   logic        reset, arm, trigger, sample_valid, write_allowed;
   logic [15:0] sample_data;
   logic [31:0] pre_count, post_count;
   logic        write_req, idle, capture_done, overflow;
   logic [31:0] writeSampleNumber, writePacket, sampleNumber_Begin, sampleNumber_End;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] pkt;
   } sb_t;
   sb_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   analyzer_capture_fsm #(
      .SAMPLE_WIDTH(16), .SAMPLE_PACKET_WIDTH(32), .MEMORY_CAPACITY(64),
      .MEMORY_WORD_WIDTH(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .arm(arm), .trigger(trigger),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .pre_count(pre_count), .post_count(post_count), .write_allowed(write_allowed),
      .write_req(write_req), .writeSampleNumber(writeSampleNumber),
      .writePacket(writePacket), .idle(idle), .capture_done(capture_done),
      .overflow(overflow), .sampleNumber_Begin(sampleNumber_Begin),
      .sampleNumber_End(sampleNumber_End)
   );

   // Every accepted memory write is matched against the oldest expected packet.
   always @(negedge clk) begin
      if (!reset && write_req && write_allowed) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_write addr=%0d pkt=%h required=none", writeSampleNumber, writePacket);
         end else begin
            sb_t e;
            e = sb.pop_front();
            if (writeSampleNumber !== e.addr || writePacket !== e.pkt)
               $display("FAIL write addr=%0d pkt=%h required addr=%0d pkt=%h",
                        writeSampleNumber, writePacket, e.addr, e.pkt);
            else n_pass++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arms, drives nsamp back-to-back samples (trigger on t1/t2) and expects
   // samples 0..last to be written; waits for DONE with the queue drained.
   task automatic run_capture(input int pre, input int post, input int nsamp,
                              input int t1, input int t2, input int last,
                              output bit ok, output logic first_req);
      first_req  = 1'bx;
      pre_count  = pre;
      post_count = post;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < nsamp; i++) begin
         logic [15:0] d;
         d = 16'($urandom);
         sample_valid = 1'b1;
         sample_data  = d;
         trigger      = (i == t1) || (i == t2);
         if (i <= last) sb.push_back('{addr: 32'(i % 16), pkt: {16'(i), d}});
         if (i == 0) begin
            @(negedge clk);
            first_req = write_req;
         end
         tick();
      end
      sample_valid = 1'b0;
      trigger      = 1'b0;
      for (int c = 0; c < 100 && !(capture_done && sb.size() == 0); c++) @(negedge clk);
      @(negedge clk);
      ok = capture_done && (sb.size() == 0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (write_req !== 1'b0 || writeSampleNumber !== 32'd0 || idle !== 1'b1 ||
          capture_done !== 1'b0 || overflow !== 1'b0 ||
          sampleNumber_Begin !== 32'd0 || sampleNumber_End !== 32'd0)
         $display("FAIL reset_state req=%b wsn=%0d idle=%b done=%b ovf=%b b=%0d e=%0d required 0,0,1,0,0,0,0",
                  write_req, writeSampleNumber, idle, capture_done, overflow,
                  sampleNumber_Begin, sampleNumber_End);
      else n_pass++;
   endtask

   task automatic test_basic();
      bit ok; logic fr;
      run_capture(4, 3, 16, 9, -1, 12, ok, fr);
      n_checks++; if (ok !== 1'b1) $display("FAIL basic_done got=%b required=1", ok); else n_pass++;
      n_checks++; if (fr !== 1'b0) $display("FAIL basic_latency write_req=%b required=0", fr); else n_pass++;
      n_checks++; if (sampleNumber_Begin !== 32'd5) $display("FAIL basic_begin got=%0d required=5", sampleNumber_Begin); else n_pass++;
      n_checks++; if (sampleNumber_End !== 32'd13) $display("FAIL basic_end got=%0d required=13", sampleNumber_End); else n_pass++;
      n_checks++; if (idle !== 1'b1 || overflow !== 1'b0) $display("FAIL basic_idle idle=%b ovf=%b required 1,0", idle, overflow); else n_pass++;
   endtask

   task automatic test_wrap();
      bit ok; logic fr;
      run_capture(4, 3, 36, 30, -1, 33, ok, fr);
      n_checks++; if (ok !== 1'b1) $display("FAIL wrap_done got=%b required=1", ok); else n_pass++;
      n_checks++; if (sampleNumber_Begin !== 32'd10) $display("FAIL wrap_begin got=%0d required=10", sampleNumber_Begin); else n_pass++;
      n_checks++; if (sampleNumber_End !== 32'd2) $display("FAIL wrap_end got=%0d required=2", sampleNumber_End); else n_pass++;
   endtask

   task automatic test_pretrig_ignore();
      bit ok; logic fr;
      run_capture(4, 3, 12, 2, 6, 9, ok, fr);
      n_checks++; if (ok !== 1'b1) $display("FAIL ignore_done got=%b required=1", ok); else n_pass++;
      n_checks++; if (sampleNumber_Begin !== 32'd2) $display("FAIL ignore_begin got=%0d required=2", sampleNumber_Begin); else n_pass++;
      n_checks++; if (sampleNumber_End !== 32'd10) $display("FAIL ignore_end got=%0d required=10", sampleNumber_End); else n_pass++;
   endtask

   task automatic test_overflow();
      sb_t head_exp;
      int  c;
      write_allowed = 1'b0;
      pre_count = 4; post_count = 3;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic [15:0] d;
         d = 16'($urandom);
         sample_valid = 1'b1;
         sample_data  = d;
         if (i < 4) sb.push_back('{addr: 32'(i), pkt: {16'(i), d}});
         tick();
      end
      sample_valid = 1'b0;
      head_exp = sb[0];
      @(negedge clk);
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%b required=1", overflow); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (write_req !== 1'b1 || writePacket !== head_exp.pkt || writeSampleNumber !== 32'd0)
            $display("FAIL ovf_hold req=%b pkt=%h wsn=%0d required 1,%h,0", write_req, writePacket,
                     writeSampleNumber, head_exp.pkt);
         else n_pass++;
         @(negedge clk);
      end
      tick();
      write_allowed = 1'b1;
      c = 0;
      while (c < 20 && sb.size() != 0) begin @(negedge clk); c++; end
      @(negedge clk);
      n_checks++; if (sb.size() != 0) $display("FAIL ovf_drain left=%0d required=0", sb.size()); else n_pass++;
      n_checks++; if (overflow !== 1'b1 || write_req !== 1'b0) $display("FAIL ovf_sticky ovf=%b req=%b required 1,0", overflow, write_req); else n_pass++;
   endtask

   // Continues from the ARMED state left by test_overflow.
   task automatic test_reset_posttrig();
      bit stray;
      tick();
      write_allowed = 1'b0;
      sample_valid = 1'b1; sample_data = 16'h1234; trigger = 1'b1;
      tick();
      trigger = 1'b0; sample_data = 16'h5678;
      tick();
      sample_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (write_req !== 1'b1 || idle !== 1'b0) $display("FAIL rst_pre req=%b idle=%b required 1,0", write_req, idle); else n_pass++;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (write_req !== 1'b0 || idle !== 1'b1 || capture_done !== 1'b0 || overflow !== 1'b0 ||
          sampleNumber_Begin !== 32'd0 || sampleNumber_End !== 32'd0 || writeSampleNumber !== 32'd0)
         $display("FAIL rst_mid req=%b idle=%b done=%b ovf=%b b=%0d e=%0d wsn=%0d required 0,1,0,0,0,0,0",
                  write_req, idle, capture_done, overflow, sampleNumber_Begin, sampleNumber_End,
                  writeSampleNumber);
      else n_pass++;
      write_allowed = 1'b1;
      stray = 1'b0;
      for (int k = 0; k < 4; k++) begin @(negedge clk); if (write_req !== 1'b0) stray = 1'b1; end
      n_checks++; if (stray !== 1'b0) $display("FAIL rst_no_write stray=%b required=0", stray); else n_pass++;
   endtask

   task automatic test_pre_clamp();
      bit ok; logic fr;
      run_capture(20, 3, 20, 14, -1, 17, ok, fr);
      n_checks++; if (ok !== 1'b1) $display("FAIL clamp_done got=%b required=1", ok); else n_pass++;
      n_checks++; if (sampleNumber_Begin !== 32'd2) $display("FAIL clamp_begin got=%0d required=2", sampleNumber_Begin); else n_pass++;
      n_checks++; if (sampleNumber_End !== 32'd2) $display("FAIL clamp_end got=%0d required=2", sampleNumber_End); else n_pass++;
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; trigger = 1'b0; sample_valid = 1'b0; sample_data = '0;
      pre_count = '0; post_count = '0; write_allowed = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      test_reset();
      tick();
      test_basic();
      tick();
      test_wrap();
      tick();
      test_pretrig_ignore();
      tick();
      test_overflow();
      test_reset_posttrig();
      tick();
      test_pre_clamp();
      n_checks++; if (sb.size() != 0) $display("FAIL sb_leftover left=%0d required=0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t required=finish", $time);
      $fatal(1, "timeout");
   end

endmodule
